uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DBIT, default 8, number of data bits per frame (legal range 5..8).
REQ-002 Parameter SB_TICK, default 16, number of s_tick periods in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 s_tick  input  1  oversampling strobe, one clk wide, 16 per bit period (from the baud rate generator).
REQ-006 rx  input  1  asynchronous serial line; idles high.
REQ-007 dout  output  8  last received byte, LSB-first assembled, zero-extended when DBIT<8.
REQ-008 rx_done_tick  output  1  one-clk pulse: dout and framing_err valid and updated.
REQ-009 framing_err  output  1  set if the stop bit of the last frame was sampled low.
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (reset value 1); the FSM SHALL use only the synchronized value rx_s.
REQ-012 FSM states SHALL be IDLE, START, DATA and STOP.
REQ-013 Counters SHALL be s (4 bits, tick count), n (3 bits, bit index) and b (8-bit shift register).
REQ-014 IDLE: when rx_s==0, go to START and clear s; s_tick is ignored in IDLE.
REQ-015 START: on s_tick with s==7 (mid start bit), if rx_s==0 go to DATA and clear s and n.
REQ-016 START: on s_tick with s==7, if rx_s==1 treat as a glitch and return to IDLE, with no pulse and no output change.
REQ-017 START: on any other s_tick, increment s.
REQ-018 DATA: on s_tick with s==15, clear s and shift right so b <= {rx_s, b[7:1]}; if n==DBIT-1 go to STOP, else increment n.
REQ-019 DATA: on any other s_tick, increment s.
REQ-020 STOP: on s_tick with s==SB_TICK-1, go to IDLE and capture the frame.
REQ-021 Frame capture: dout <= b right-aligned by 8-DBIT; framing_err <= ~rx_s; rx_done_tick pulses high for exactly one clk in the following cycle.
REQ-022 STOP: on any other s_tick, increment s; s SHALL be wide enough for SB_TICK-1 (5 bits when SB_TICK>16).
REQ-023 Without s_tick, state and counters SHALL hold; no state advances more than one step per clk.
REQ-024 A frame with framing_err SHALL still update dout and pulse rx_done_tick.
REQ-025 A start edge arriving in the clk right after return to IDLE SHALL be accepted (back-to-back frames).
REQ-026 dout and framing_err SHALL hold their values between rx_done_tick pulses.
REQ-027 busy SHALL be registered-state decoded: 0 in IDLE, 1 otherwise.

Reset
REQ-028 While reset_n==0 (asynchronous assert), the block SHALL hold: state=IDLE, s=0, n=0, b=0, dout=0, framing_err=0, rx_done_tick=0, synchronizer flops=1.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, reception resumes only on a new falling edge.

Structure
REQ-030 The state enum type (IDLE/START/DATA/STOP) and the constant OVERSAMPLE=16 SHALL live in a shared package uart_pkg, also used by the future uart_tx.
REQ-031 The 2-flop synchronizer SHALL be a sub-module sync_2ff (clk, reset_n, d, q, reset value parameter).
REQ-032 The block SHALL have no other sub-modules; the baud rate generator is instantiated at top level, not inside uart_rx.

Verification
REQ-033 Drive s_tick every 4 clk and send 0xA5 with 1 stop bit -> one rx_done_tick, dout=0xA5, framing_err=0.
REQ-034 Send a 0x55 frame with the stop bit held low -> rx_done_tick, dout=0x55, framing_err=1.
REQ-035 Pull rx low for 3 s_tick periods then high -> no rx_done_tick, busy returns to 0 at the s==7 sample.
REQ-036 Send 0x00 then 0xFF back-to-back with no idle gap -> two pulses, dout=0x00 then 0xFF.
REQ-037 Assert reset_n=0 during data bit 4 of a frame -> outputs at reset values, no pulse; the next 0x3C frame is received correctly.
REQ-038 Set DBIT=7, SB_TICK=32 and send 0x41 -> dout=0x41, pulse 32 s_tick periods after the last data sample.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling ratio,
// common to the receiver and the future transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // s_tick strobes per serial bit period
    localparam int OVERSAMPLE = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; both flops reset to the line's idle level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling: detects the start edge, samples
// each data bit in its middle, checks the stop bit and presents the byte.
//
// Output contract: rx_done_tick is a one-clk valid strobe with no ready
// (the receiver cannot be stalled); dout and framing_err change only in
// the cycle rx_done_tick is high and hold their values until the next one.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s_tick,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       framing_err,
    output logic       busy
);

    // Tick counter must reach SB_TICK-1 for stop bits longer than one bit
    localparam int SW = (SB_TICK > OVERSAMPLE) ? 5 : 4;

    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [2:0]    N_LAST = 3'(DBIT - 1);
    // Bits shift in from the MSB end, so short frames sit high in b
    localparam int            ALIGN  = 8 - DBIT;

    uart_state_t   state, state_nx;
    logic [SW-1:0] s, s_nx;
    logic [2:0]    n, n_nx;
    logic [7:0]    b, b_nx;
    logic [7:0]    dout_nx;
    logic          framing_err_nx;
    logic          rx_done_nx;
    logic          rx_s;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    // State, counters and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            dout         <= '0;
            framing_err  <= 1'b0;
            rx_done_tick <= 1'b0;
        end else begin
            state        <= state_nx;
            s            <= s_nx;
            n            <= n_nx;
            b            <= b_nx;
            dout         <= dout_nx;
            framing_err  <= framing_err_nx;
            rx_done_tick <= rx_done_nx;
        end
    end

    // Next-state and datapath: everything holds unless an s_tick advances it
    always_comb begin
        state_nx       = state;
        s_nx           = s;
        n_nx           = n;
        b_nx           = b;
        dout_nx        = dout;
        framing_err_nx = framing_err;
        rx_done_nx     = 1'b0;
        case (state)
            IDLE: begin
                // Start edge is seen regardless of s_tick phase
                if (!rx_s) begin
                    state_nx = START;
                    s_nx     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == S_MID) begin
                        if (!rx_s) begin
                            state_nx = DATA;
                            s_nx     = '0;
                            n_nx     = '0;
                        end else begin
                            // Line went back high before mid start bit: glitch
                            state_nx = IDLE;
                        end
                    end else begin
                        s_nx = s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == S_LAST) begin
                        s_nx = '0;
                        b_nx = {rx_s, b[7:1]};
                        if (n == N_LAST) begin
                            state_nx = STOP;
                        end else begin
                            n_nx = n + 1'b1;
                        end
                    end else begin
                        s_nx = s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s == S_STOP) begin
                        state_nx       = IDLE;
                        dout_nx        = b >> ALIGN;
                        framing_err_nx = ~rx_s;
                        rx_done_nx     = 1'b1;
                    end else begin
                        s_nx = s + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
